pe_traffic_gen: RTL and testbench
=================================

# pe_traffic_gen

Processing-element stub that sits directly upstream of each mesh node's NIC and drives its CPU-side port (addr/d_in/d_out/nicEn/nicEnWR). On start it injects NUM_PKTS packets addressed to a programmable destination router, interleaving output-buffer writes with input-buffer polling so received packets are drained and counted. Used in place of a CPU for mesh bring-up and traffic tests.

## Interface
- SRC_X, 0, this node's column (0-3)
- SRC_Y, 0, this node's row (0-3)
- NUM_PKTS, 8, packets injected per run (1-255)
- PACKET_WIDTH, 64, packet width; only 64 supported
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  level; rising edge in IDLE begins a run
- dest_x, dest_y  input  2 each  destination router, sampled on start
- addr  output  2  NIC register select
- d_in  output  64  packet to NIC
- d_out  input  64  NIC read data
- nicEn, nicEnWR  output  1 each  NIC access enable / write enable
- tx_count, rx_count  output  8 each  packets written / read
- rx_last  output  64  most recently read packet
- done  output  1  all NUM_PKTS written

## Operation
- NIC map: 00 input buffer (read), 01 input status (d_out[0]=1: packet waiting), 10 output buffer (write), 11 output status (d_out[0]=1: full).
- Packet: [63] vc=0; [62] x dir (0 east/+x, 1 west); [61] y dir (0 north/+y, 1 south); [60:56] zero; [55:52] x hops = |dest_x-SRC_X|; [51:48] y hops = |dest_y-SRC_Y|; [47:44] {SRC_X,SRC_Y}; [43:40] {dest_x,dest_y}; [39:32] sequence = tx_count; [31:0] 32'hA5A5_0000 | tx_count. Hops computed unsigned from registered dest (3-bit difference, no wrap).
- States: IDLE, TX_POLL, TX_CHK, TX_WR, RX_POLL, RX_CHK, RX_RD, RX_CAP, HOLD.
- IDLE: on start rising edge capture dest, clear counters/done, go TX_POLL.
- TX_POLL: read addr 11 -> TX_CHK. TX_CHK: d_out[0]=0 -> TX_WR; else -> RX_POLL.
- TX_WR: nicEn=nicEnWR=1, addr 10, d_in=packet; tx_count++; -> RX_POLL.
- RX_POLL: read addr 01 -> RX_CHK. RX_CHK: d_out[0]=1 -> RX_RD; else -> TX_POLL if tx_count<NUM_PKTS, else HOLD.
- RX_RD: read addr 00 -> RX_CAP. RX_CAP: rx_last<=d_out, rx_count++ (wraps 255->0) -> same branch as RX_CHK-empty.
- HOLD: done=1; RX_POLL every 4th cycle (2-bit counter) so late arrivals still drain; start low -> IDLE (done stays 1 until next start).
- start held high after a run does not retrigger; edge detector required.

## Timing
- NIC reads: nicEn=1, nicEnWR=0 in poll/read state; d_out sampled one cycle later (CHK/CAP state). Writes commit at the edge ending TX_WR.
- nicEn, nicEnWR, addr, d_in registered (Moore); nicEn high exactly one cycle per access; d_in=0 whenever nicEnWR=0.
- Best-case injection: one packet per 4 cycles (TX_POLL,TX_CHK,TX_WR,RX_POLL) plus RX_CHK = 5 cycles with empty input.
- Reset (any state, mid-access included): state IDLE, addr=0, d_in=0, nicEn=0, nicEnWR=0, counters=0, rx_last=0, done=0, dest=0, start-edge register=0. Async assertion; deassertion synchronous to clk.
- Full output buffer never stalls receive: TX_CHK full always falls through to RX_POLL.
- dest equal to source: hops 0,0, packet still written.

## Test plan
- Reset mid TX_WR (reset=0 for 1 cycle) -> nicEn/nicEnWR 0 immediately, state IDLE, tx_count 0, no further access until new start edge.
- SRC=(0,0), dest=(3,2), NUM_PKTS=4, NIC never full/empty -> four writes, d_in[62:48]=0,0,4'h3,4'h2, sequence 0..3, done=1 after 4th write, 20 cycles from start.
- SRC=(2,3), dest=(0,1) -> d_in[62]=1, [61]=1, hops 2,2, [47:40]=8'hB1.
- Output status full for 10 cycles -> no write with nicEnWR during that time, RX polled each loop, tx resumes when full clears; total writes exactly NUM_PKTS.
- Input status 1 with d_out=64'h1234 on read -> rx_last=64'h1234, rx_count+1; in HOLD, packet arriving still drained within 8 cycles.
- start held high through done -> no second run; start low then high -> counters cleared, new run.

Source files
------------

// File: rtl/pe_traffic_gen.sv
// rtl/pe_traffic_gen.sv - PE stub that injects NUM_PKTS packets into its NIC and drains received packets
module pe_traffic_gen #(
  parameter int SRC_X        = 0,
  parameter int SRC_Y        = 0,
  parameter int NUM_PKTS     = 8,
  parameter int PACKET_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              dest_x,
  input  logic [1:0]              dest_y,
  output logic [1:0]              addr,
  output logic [PACKET_WIDTH-1:0] d_in,
  input  logic [PACKET_WIDTH-1:0] d_out,
  output logic                    nicEn,
  output logic                    nicEnWR,
  output logic [7:0]              tx_count,
  output logic [7:0]              rx_count,
  output logic [PACKET_WIDTH-1:0] rx_last,
  output logic                    done
);

  localparam logic [1:0] SX = SRC_X[1:0];
  localparam logic [1:0] SY = SRC_Y[1:0];
  localparam logic [7:0] NP = NUM_PKTS[7:0];

  localparam logic [1:0] A_IBUF = 2'b00;
  localparam logic [1:0] A_ISTS = 2'b01;
  localparam logic [1:0] A_OBUF = 2'b10;
  localparam logic [1:0] A_OSTS = 2'b11;

  typedef enum logic [3:0] {
    IDLE, TX_POLL, TX_CHK, TX_WR, RX_POLL, RX_CHK, RX_RD, RX_CAP, HOLD
  } state_t;

  state_t state, next_state;

  logic [1:0]              dest_x_q, dest_y_q;
  logic                    start_q;
  logic                    start_rise;
  logic [1:0]              hold_cnt;
  logic                    more_tx;
  logic                    x_west, y_south;
  logic [3:0]              x_hops, y_hops;
  logic [PACKET_WIDTH-1:0] packet;

  logic [1:0]              addr_nx;
  logic [PACKET_WIDTH-1:0] d_in_nx;
  logic                    nic_en_nx, nic_wr_nx;

  assign start_rise = start & ~start_q;
  assign more_tx    = tx_count < NP;

  // Coordinates never wrap, so the 2-bit absolute difference is exact.
  assign x_west  = dest_x_q < SX;
  assign y_south = dest_y_q < SY;
  assign x_hops  = x_west  ? {2'b00, SX - dest_x_q} : {2'b00, dest_x_q - SX};
  assign y_hops  = y_south ? {2'b00, SY - dest_y_q} : {2'b00, dest_y_q - SY};

  assign packet = {1'b0, x_west, y_south, 5'b00000, x_hops, y_hops,
                   SX, SY, dest_x_q, dest_y_q, tx_count,
                   32'hA5A5_0000 | {24'h000000, tx_count}};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_rise) next_state = TX_POLL;
      TX_POLL: next_state = TX_CHK;
      TX_CHK:  next_state = d_out[0] ? RX_POLL : TX_WR;
      TX_WR:   next_state = RX_POLL;
      RX_POLL: next_state = RX_CHK;
      RX_CHK:  next_state = d_out[0] ? RX_RD : (more_tx ? TX_POLL : HOLD);
      RX_RD:   next_state = RX_CAP;
      RX_CAP:  next_state = more_tx ? TX_POLL : HOLD;
      HOLD: begin
        if (!start)                next_state = IDLE;
        else if (hold_cnt == 2'd3) next_state = RX_POLL;
      end
      default: next_state = IDLE;
    endcase
  end

  // NIC strobes are decoded from the state being entered so they register alongside it.
  always_comb begin
    addr_nx   = 2'b00;
    d_in_nx   = '0;
    nic_en_nx = 1'b0;
    nic_wr_nx = 1'b0;
    case (next_state)
      TX_POLL: begin nic_en_nx = 1'b1; addr_nx = A_OSTS; end
      TX_WR: begin
        nic_en_nx = 1'b1;
        nic_wr_nx = 1'b1;
        addr_nx   = A_OBUF;
        d_in_nx   = packet;
      end
      RX_POLL: begin nic_en_nx = 1'b1; addr_nx = A_ISTS; end
      RX_RD:   begin nic_en_nx = 1'b1; addr_nx = A_IBUF; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      addr     <= 2'b00;
      d_in     <= '0;
      nicEn    <= 1'b0;
      nicEnWR  <= 1'b0;
      tx_count <= 8'd0;
      rx_count <= 8'd0;
      rx_last  <= '0;
      done     <= 1'b0;
      dest_x_q <= 2'b00;
      dest_y_q <= 2'b00;
      start_q  <= 1'b0;
      hold_cnt <= 2'd0;
    end else begin
      state    <= next_state;
      addr     <= addr_nx;
      d_in     <= d_in_nx;
      nicEn    <= nic_en_nx;
      nicEnWR  <= nic_wr_nx;
      start_q  <= start;
      hold_cnt <= (state == HOLD) ? hold_cnt + 2'd1 : 2'd0;

      if (state == IDLE && start_rise) begin
        dest_x_q <= dest_x;
        dest_y_q <= dest_y;
        tx_count <= 8'd0;
        rx_count <= 8'd0;
      end
      if (state == TX_WR) tx_count <= tx_count + 8'd1;
      if (state == RX_CAP) begin
        rx_last  <= d_out;
        rx_count <= rx_count + 8'd1;
      end

      // done is sticky through IDLE until the next run begins.
      if (state == IDLE && start_rise) done <= 1'b0;
      else if (next_state == HOLD)     done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_traffic_gen.sv
// tb/tb_pe_traffic_gen.sv - self-checking bench for pe_traffic_gen with a behavioural NIC
module tb_pe_traffic_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  dest_x = 2'd0, dest_y = 2'd0;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out = 64'd0;
  logic        nicEn, nicEnWR;
  logic [7:0]  tx_count, rx_count;
  logic [63:0] rx_last;
  logic        done;

  always #5 clk = ~clk;

  pe_traffic_gen #(.SRC_X(2), .SRC_Y(3), .NUM_PKTS(4), .PACKET_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .dest_x(dest_x), .dest_y(dest_y),
    .addr(addr), .d_in(d_in), .d_out(d_out), .nicEn(nicEn), .nicEnWR(nicEnWR),
    .tx_count(tx_count), .rx_count(rx_count), .rx_last(rx_last), .done(done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // NIC model: read data appears on d_out the cycle after the access.
  bit          full = 1'b0;
  logic [63:0] rx_q[$];
  logic [63:0] rd_v;
  always @(posedge clk) begin
    if (nicEn && !nicEnWR) begin
      rd_v = 64'd0;
      case (addr)
        2'd0: if (rx_q.size() > 0) rd_v = rx_q.pop_front();
        2'd1: rd_v = {63'd0, rx_q.size() > 0};
        2'd3: rd_v = {63'd0, full};
        default: rd_v = 64'd0;
      endcase
      d_out <= rd_v;
    end
  end

  // Write scoreboard and access counters, sampled on the falling edge.
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  int wr_cnt = 0, rxpoll_cnt = 0, acc_cnt = 0;
  always @(negedge clk) begin
    if (reset) begin
      if (nicEn) acc_cnt++;
      if (nicEn && !nicEnWR && addr == 2'd1) rxpoll_cnt++;
      if (nicEn && nicEnWR) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h expected no write", d_in);
        end else begin
          exp_v = exp_q.pop_front();
          check("tx_packet", d_in, exp_v);
        end
      end else if (d_in !== 64'd0) begin
        check("d_in_idle_zero", d_in, 64'd0);
      end
    end
  end

  typedef struct {
    logic [1:0]  dx;
    logic [1:0]  dy;
    logic [23:0] hdr;
  } vec_t;
  vec_t tbl[5];

  task automatic push_expected(input logic [23:0] hdr);
    for (int s = 0; s < 4; s++)
      exp_q.push_back({hdr, 8'(s), 32'hA5A5_0000 | 32'(s)});
  endtask

  task automatic run_case(input logic [1:0] dx, input logic [1:0] dy, input logic [23:0] hdr,
                          input int exp_cyc);
    int cyc;
    dest_x = dx;
    dest_y = dy;
    push_expected(hdr);
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    check("start_clears", {done, tx_count}, 9'd0);
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_reached", 64'(done), 64'd1);
    if (exp_cyc > 0) check("done_latency", 64'(cyc), 64'(exp_cyc));
    check("tx_count_final", 64'(tx_count), 64'd4);
    check("all_packets_written", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic hold_and_release();
    int w0;
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("no_retrigger_writes", 64'(wr_cnt - w0), 64'd0);
    check("hold_done", {done, tx_count}, {1'b1, 8'd4});
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_done_sticky", 64'(done), 64'd1);
  endtask

  int w0, p0, a0, k;
  bit found;

  initial begin
    tbl[0] = '{2'd0, 2'd1, 24'h6022B1};
    tbl[1] = '{2'd3, 2'd3, 24'h0010BF};
    tbl[2] = '{2'd2, 2'd3, 24'h0000BB};
    tbl[3] = '{2'd3, 2'd0, 24'h2013BC};
    tbl[4] = '{2'd0, 2'd3, 24'h4020B3};

    repeat (2) @(posedge clk); #1;
    check("rst_outputs", {addr, nicEn, nicEnWR, done, tx_count, rx_count}, 21'd0);
    check("rst_d_in", d_in, 64'd0);
    check("rst_rx_last", rx_last, 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_case(tbl[i].dx, tbl[i].dy, tbl[i].hdr, 21);
      hold_and_release();
    end

    // Output buffer full: transmit must stall while receive keeps polling.
    full = 1'b1;
    dest_x = 2'd0;
    dest_y = 2'd1;
    push_expected(24'h6022B1);
    w0 = wr_cnt;
    p0 = rxpoll_cnt;
    @(negedge clk) start = 1'b1;
    repeat (10) @(negedge clk);
    check("no_write_while_full", 64'(wr_cnt - w0), 64'd0);
    check("rx_polled_while_full", 64'(rxpoll_cnt - p0 >= 2), 64'd1);
    full = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("full_done", 64'(done), 64'd1);
    check("full_total_writes", 64'(wr_cnt - w0), 64'd4);
    check("full_queue_empty", 64'(exp_q.size()), 64'd0);
    hold_and_release();

    // Receive path, then a late arrival drained from HOLD.
    rx_q.push_back(64'h1234);
    run_case(2'd3, 2'd3, 24'h0010BF, 0);
    check("rx_last_first", rx_last, 64'h1234);
    check("rx_count_first", 64'(rx_count), 64'd1);
    @(negedge clk) rx_q.push_back(64'hBEEF_0001);
    k = 0;
    while (rx_count != 8'd2 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("hold_drain_count", 64'(rx_count), 64'd2);
    check("hold_drain_data", rx_last, 64'hBEEF_0001);
    hold_and_release();

    // Reset in the middle of the second write.
    dest_x = 2'd2;
    dest_y = 2'd3;
    push_expected(24'h0000BB);
    @(negedge clk) start = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (nicEnWR && tx_count == 8'd1) found = 1'b1;
    end
    check("reached_second_write", 64'(found), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_wr_strobes", {nicEn, nicEnWR, addr}, 4'd0);
    check("rst_mid_wr_counts", {done, tx_count, rx_count}, 17'd0);
    check("rst_mid_wr_d_in", d_in, 64'd0);
    start = 1'b0;
    @(negedge clk) reset = 1'b1;
    exp_q.delete();
    a0 = acc_cnt;
    repeat (10) @(negedge clk);
    check("no_access_after_reset", 64'(acc_cnt - a0), 64'd0);
    check("tx_count_after_reset", 64'(tx_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
